jolt160_mem_arbiter: RTL and testbench
======================================

Name: jolt160_mem_arbiter

Overview:
Two-master arbiter that shares the single Jolt160 memory port between the CPU core and a DMA engine. Each master issues one 8- or 16-bit read or write per request. The arbiter registers the winning request onto the memory port, waits for mem_ready, returns the read data and a one-cycle ready pulse to the owner, and flags timeouts. The CPU has fixed priority, with a bounded-starvation guarantee for DMA.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 16, data bus width
DMA_MAX_WAIT, 4, lost arbitrations after which DMA wins the next arbitration (1..15)
TIMEOUT, 255, cycles without mem_ready before the access is aborted (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU request; held high with fields stable until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_sz  in  1  0 = 8-bit, 1 = 16-bit
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rdata  out  DATA_WIDTH  CPU read data, valid while cpu_ready is high
cpu_ready  out  1  one-cycle completion pulse to CPU
dma_req, dma_we, dma_sz, dma_addr, dma_wdata  in  as CPU equivalents  DMA request fields
dma_rdata  out  DATA_WIDTH  DMA read data
dma_ready  out  1  one-cycle completion pulse to DMA
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_sz  out  1  memory access size
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, single-cycle
bus_owner  out  2  00 = idle, 01 = CPU, 10 = DMA
bus_err  out  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, GRANT_CPU, GRANT_DMA, DONE.
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including mem_* fields, rdata regs, ready, bus_owner and bus_err.
  - The starvation counter and timeout counter clear.
  - Reset mid-access drops mem_req on the next edge. No ready pulse is generated.
- IDLE arbitration, in priority order:
  - If dma_req and starve_cnt == DMA_MAX_WAIT: go to GRANT_DMA.
  - Else if cpu_req: go to GRANT_CPU. If dma_req is also high, starve_cnt increments, saturating at DMA_MAX_WAIT.
  - Else if dma_req: go to GRANT_DMA.
  - Else stay in IDLE.
  - Any DMA grant clears starve_cnt.
- Grant entry (registered, one cycle after the req is seen in IDLE):
  - mem_req = 1.
  - mem_we, mem_sz, mem_addr and mem_wdata are latched from the winner.
  - bus_owner is set.
  - tmo_cnt clears.
- GRANT_x:
  - mem_req and the latched fields stay constant. Requester input changes are ignored.
  - On mem_ready:
    - Capture mem_rdata into the owner's rdata reg. Writes also capture; the value is don't-care to the master.
    - Drop mem_req.
    - Go to DONE.
  - Without mem_ready, tmo_cnt increments. When tmo_cnt == TIMEOUT-1 and mem_ready is still low:
    - Drop mem_req.
    - Pulse bus_err.
    - Go to DONE. The owner's ready still pulses, with rdata = 0.
- DONE (exactly one cycle):
  - The owner's ready = 1.
  - bus_owner holds.
  - mem_req = 0.
  - All req inputs are ignored.
  - Next state is IDLE, with bus_owner = 00.
- Requester rule: deassert req in the ready cycle. A req still high in the following IDLE cycle is treated as a new request.
- Rdata regs hold their value until the next completion for that master.
- mem_ready seen outside GRANT_x is ignored.
- Minimum access latency: req sampled at cycle N, mem_req high at N+1, mem_ready at N+1 gives ready at N+2, and a new grant is possible at N+3.
- 8-bit accesses pass sz through unchanged; byte lane selection belongs to the memory.

Test Plan:
1. CPU read at 0x1234, memory returns 0xBEEF with mem_ready two cycles after mem_req -> mem_addr = 0x1234, mem_we = 0, cpu_ready pulses once with cpu_rdata = 0xBEEF, dma_ready stays 0, bus_owner goes 01 then 00.
2. DMA 8-bit write of 0x00A5 at 0x8000, zero-wait memory -> mem_sz = 0, mem_wdata = 0x00A5, dma_ready at req+2, bus_owner = 10.
3. cpu_req and dma_req both held continuously with DMA_MAX_WAIT = 4 -> grant order CPU, CPU, CPU, CPU, DMA, then repeating; starve_cnt is 0 after each DMA grant.
4. CPU access with mem_ready never asserted, TIMEOUT = 8 -> mem_req high for exactly 8 cycles, bus_err and cpu_ready pulse together, cpu_rdata = 0.
5. Reset asserted while in GRANT_DMA -> next edge has mem_req = 0, bus_owner = 00, no dma_ready; a later CPU request is granted normally.
6. cpu_addr changed while in GRANT_CPU, and cpu_req held high through DONE -> mem_addr unchanged during the access; a second CPU access starts from IDLE at DONE+1.

Source files
------------

// File: rtl/jolt160_mem_arbiter_if.sv
// Signal bundle between the CPU/DMA requesters, the Jolt160 memory port and the arbiter.
// The arbiter connects through the slave view; the requester/memory side uses the master view.
interface jolt160_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic                  cpu_sz;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;

  logic                  dma_req;
  logic                  dma_we;
  logic                  dma_sz;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_ready;

  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_sz;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  logic [1:0]            bus_owner;
  logic                  bus_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_sz, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_we, dma_sz, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_req, mem_we, mem_sz, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output bus_owner, bus_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_sz, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_we, dma_sz, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_req, mem_we, mem_sz, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  bus_owner, bus_err
  );
endinterface

// File: rtl/jolt160_mem_arbiter.sv
// CPU/DMA arbiter for the Jolt160 memory port: fixed CPU priority, DMA wins after DMA_MAX_WAIT losses.
// Grant is registered one cycle after the request; the owner's ready pulses one cycle after mem_ready or timeout.
module jolt160_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int DMA_MAX_WAIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  jolt160_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_CPU, GRANT_DMA, DONE} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(DMA_MAX_WAIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic [7:0] tmo_cnt;
  logic       grant_cpu;
  logic       grant_dma;
  logic       access_ok;
  logic       access_tmo;
  logic       in_grant;

  assign in_grant = (state == GRANT_CPU) || (state == GRANT_DMA);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_cpu  = 1'b0;
    grant_dma  = 1'b0;
    access_ok  = 1'b0;
    access_tmo = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dma_req && (starve_cnt == STARVE_MAX)) begin
          grant_dma = 1'b1;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
          if (bus.dma_req && (starve_cnt < STARVE_MAX)) starve_nxt = starve_cnt + 4'd1;
        end else if (bus.dma_req) begin
          grant_dma = 1'b1;
        end
        if (grant_dma) begin
          starve_nxt = '0;
          state_nxt  = GRANT_DMA;
        end else if (grant_cpu) begin
          state_nxt  = GRANT_CPU;
        end
      end
      GRANT_CPU, GRANT_DMA: begin
        if (bus.mem_ready) begin
          access_ok = 1'b1;
          state_nxt = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          access_tmo = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_sz    <= 1'b0;
      bus.mem_addr  <= {ADDR_WIDTH{1'b0}};
      bus.mem_wdata <= {DATA_WIDTH{1'b0}};
      bus.cpu_rdata <= {DATA_WIDTH{1'b0}};
      bus.dma_rdata <= {DATA_WIDTH{1'b0}};
      bus.cpu_ready <= 1'b0;
      bus.dma_ready <= 1'b0;
      bus.bus_owner <= 2'b00;
      bus.bus_err   <= 1'b0;
    end else begin
      starve_cnt    <= starve_nxt;
      bus.cpu_ready <= 1'b0;
      bus.dma_ready <= 1'b0;
      bus.bus_err   <= 1'b0;

      if (grant_cpu || grant_dma) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= grant_cpu ? bus.cpu_we    : bus.dma_we;
        bus.mem_sz    <= grant_cpu ? bus.cpu_sz    : bus.dma_sz;
        bus.mem_addr  <= grant_cpu ? bus.cpu_addr  : bus.dma_addr;
        bus.mem_wdata <= grant_cpu ? bus.cpu_wdata : bus.dma_wdata;
        bus.bus_owner <= grant_cpu ? 2'b01 : 2'b10;
        tmo_cnt       <= '0;
      end

      if (in_grant && !bus.mem_ready) tmo_cnt <= tmo_cnt + 8'd1;

      // A timed-out access still completes to its owner, but with zero data.
      if (access_ok || access_tmo) begin
        bus.mem_req <= 1'b0;
        bus.bus_err <= access_tmo;
        if (state == GRANT_CPU) begin
          bus.cpu_rdata <= access_ok ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
          bus.cpu_ready <= 1'b1;
        end else begin
          bus.dma_rdata <= access_ok ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
          bus.dma_ready <= 1'b1;
        end
      end

      if (state == DONE) bus.bus_owner <= 2'b00;
    end
  end
endmodule

// File: tb/tb_jolt160_mem_arbiter.sv
// Random CPU/DMA traffic against a responding memory, checked cycle by cycle against a transaction-level reference.
module tb_jolt160_mem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int DMW  = 4;
  localparam int TMO  = 8;
  localparam int NCYC = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jolt160_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  jolt160_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMA_MAX_WAIT(DMW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Values presented to the DUT for the coming edge (index 0 = CPU, 1 = DMA).
  logic          rst_v;
  logic          req_v  [2];
  logic          we_v   [2];
  logic          sz_v   [2];
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wd_v   [2];
  logic          mrdy_v;
  logic [DW-1:0] mrd_v;

  // Reference: ph 0 = free, 1 = access in flight, 2 = completion cycle; own 1 = CPU, 2 = DMA.
  int            ph, own, starve, cnt;
  logic          err;
  logic [DW-1:0] exp_rd [2];
  logic          mf_we, mf_sz;
  logic [AW-1:0] mf_addr;
  logic [DW-1:0] mf_wd;

  int   n_tmo = 0;
  int   n_starve = 0;
  bit   rst_done = 1'b0;
  int   mcnt = 0;
  int   mlat = 0;
  logic last_mreq = 1'b0;

  task automatic apply();
    reset         = rst_v;
    bif.cpu_req   = req_v[0];  bif.dma_req   = req_v[1];
    bif.cpu_we    = we_v[0];   bif.dma_we    = we_v[1];
    bif.cpu_sz    = sz_v[0];   bif.dma_sz    = sz_v[1];
    bif.cpu_addr  = addr_v[0]; bif.dma_addr  = addr_v[1];
    bif.cpu_wdata = wd_v[0];   bif.dma_wdata = wd_v[1];
    bif.mem_ready = mrdy_v;
    bif.mem_rdata = mrd_v;
  endtask

  task automatic new_fields(input int i);
    we_v[i]   = 1'($urandom);
    sz_v[i]   = 1'($urandom);
    addr_v[i] = AW'($urandom);
    wd_v[i]   = DW'($urandom);
  endtask

  // Advance the reference by one edge using the inputs that were presented to it.
  task automatic model_step();
    int win;
    if (rst_v) begin
      ph = 0; own = 0; starve = 0; cnt = 0; err = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      mf_we = 1'b0; mf_sz = 1'b0; mf_addr = '0; mf_wd = '0;
    end else begin
      case (ph)
        0: begin
          win = 0;
          if (req_v[1] && starve == DMW) begin
            win = 2;
            n_starve++;
          end else if (req_v[0]) begin
            win = 1;
            if (req_v[1]) starve = (starve + 1 > DMW) ? DMW : starve + 1;
          end else if (req_v[1]) begin
            win = 2;
          end
          if (win != 0) begin
            ph = 1; own = win; cnt = 0;
            if (win == 2) starve = 0;
            mf_we = we_v[win-1]; mf_sz = sz_v[win-1];
            mf_addr = addr_v[win-1]; mf_wd = wd_v[win-1];
          end
        end
        1: begin
          if (mrdy_v) begin
            ph = 2; err = 1'b0; exp_rd[own-1] = mrd_v;
          end else if (cnt == TMO - 1) begin
            ph = 2; err = 1'b1; exp_rd[own-1] = '0; n_tmo++;
          end else begin
            cnt++;
          end
        end
        default: ph = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("mem_req",   32'(bif.mem_req),   32'(ph == 1));
    chk("bus_owner", 32'(bif.bus_owner), (ph == 0) ? 32'd0 : 32'(own));
    chk("cpu_ready", 32'(bif.cpu_ready), 32'(ph == 2 && own == 1));
    chk("dma_ready", 32'(bif.dma_ready), 32'(ph == 2 && own == 2));
    chk("bus_err",   32'(bif.bus_err),   32'(ph == 2 && err));
    chk("cpu_rdata", 32'(bif.cpu_rdata), 32'(exp_rd[0]));
    chk("dma_rdata", 32'(bif.dma_rdata), 32'(exp_rd[1]));
    if (ph == 1 || rst_v) begin
      chk("mem_we",    32'(bif.mem_we),    32'(mf_we));
      chk("mem_sz",    32'(bif.mem_sz),    32'(mf_sz));
      chk("mem_addr",  32'(bif.mem_addr),  32'(mf_addr));
      chk("mem_wdata", 32'(bif.mem_wdata), 32'(mf_wd));
    end
  endtask

  task automatic drive_next(input int c);
    logic rdy_obs [2];
    bit   hold;
    rdy_obs[0] = bif.cpu_ready;
    rdy_obs[1] = bif.dma_ready;
    hold  = (c >= 700 && c < 1000);
    rst_v = (c < 3);

    if (!rst_done && c >= 1300 && ph == 1 && own == 2) begin
      // Reset in the middle of a DMA access: no ready may follow.
      rst_v    = 1'b1;
      rst_done = 1'b1;
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
    end else if (c >= 3) begin
      for (int i = 0; i < 2; i++) begin
        if (req_v[i] && rdy_obs[i]) begin
          if (hold) new_fields(i);
          else      req_v[i] = 1'b0;
        end else if (!req_v[i]) begin
          if (hold || $urandom_range(0, 3) == 0) begin
            req_v[i] = 1'b1;
            new_fields(i);
          end
        end else if ($urandom_range(0, 5) == 0) begin
          addr_v[i] = AW'($urandom);
          wd_v[i]   = DW'($urandom);
        end
      end
    end

    if (bif.mem_req) begin
      if (!last_mreq) begin
        mcnt = 0;
        mlat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      end else begin
        mcnt++;
      end
      mrdy_v = (mcnt == mlat);
    end else begin
      mrdy_v = ($urandom_range(0, 7) == 0);
    end
    last_mreq = bif.mem_req;
    mrd_v     = DW'($urandom);
  endtask

  initial begin
    rst_v  = 1'b1;
    mrdy_v = 1'b0;
    mrd_v  = '0;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; sz_v[i] = 1'b0;
      addr_v[i] = '0;  wd_v[i] = '0;  exp_rd[i] = '0;
    end
    ph = 0; own = 0; starve = 0; cnt = 0; err = 1'b0;
    mf_we = 1'b0; mf_sz = 1'b0; mf_addr = '0; mf_wd = '0;
    apply();

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      model_step();
      check_outputs();
      drive_next(c);
      apply();
    end

    chk("reset_mid_dma_seen", 32'(rst_done), 32'd1);
    chk("timeout_seen",       32'(n_tmo > 0), 32'd1);
    chk("starve_grant_seen",  32'(n_starve > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
